video_motion_ctrl: RTL
======================

# video_motion_ctrl

Per-frame motion controller for the pixel-drawing datapath. On each new video frame it sequences position updates for `NUM_OBJ` rectangular objects with edge bounce, one object per enabled cycle. It then commits the whole set atomically to output registers, so the drawing logic never sees a half-updated frame. It sits beside the video pipeline on the same `clk_i`/`cen_i` domain and replaces ad-hoc box-motion logic inside draw blocks.

## Interface
- `NUM_OBJ`, default 4: number of objects, range 1–8.
- `X_MAX`, default 1919: last visible column.
- `Y_MAX`, default 1079: last visible row.
- `OBJ_W`, default 200: object width in pixels.
- `OBJ_H`, default 200: object height in pixels.
- `STEP`, default 10: pixels moved per update.
- `FRAME_DIV`, default 4: update period in frames; used only with the macro in Configuration.

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `cen_i` input 1: video clock enable; all state advances only when high.
- `vh_blank_i` input 2: {Vblank, Hblank}.
- `run_i` input 1: motion enable, sampled at trigger.
- `obj_x_o` output `NUM_OBJ*11`: committed X of object k at bits [11k+10:11k].
- `obj_y_o` output `NUM_OBJ*11`: committed Y, same packing.
- `busy_o` output 1: high from CALC through COMMIT.
- `upd_done_o` output 1: one-clk pulse in the COMMIT cycle.
- `overrun_o` output 1: sticky; a trigger arrived while busy.
- `frame_cnt_o` output 16: frames seen, wraps at 0xFFFF→0.

## Operation
- **Trigger:**
  - Register `vblank_q` on `cen_i`.
  - A trigger is `cen_i & vh_blank_i[1] & ~vblank_q`.
  - Each trigger increments `frame_cnt_o`, including when busy or when `run_i` is low.
- **FSM states:** IDLE, CALC, COMMIT.
  - IDLE: on trigger with `run_i`=1 → CALC, `idx`=0. With `run_i`=0 → stay in IDLE; no commit, no pulse.
  - CALC: each `cen_i` cycle updates working entry `idx`. At `idx`=`NUM_OBJ`-1 → COMMIT, else `idx`+1.
  - COMMIT: on a `cen_i` cycle, copy all working registers to the outputs, pulse `upd_done_o`, → IDLE.
- **Trigger while in CALC/COMMIT:** ignored for motion, sets `overrun_o`.
- **Axis step** (per axis, 12-bit arithmetic, `LIM` = `X_MAX`-`OBJ_W`+1 or `Y_MAX`-`OBJ_H`+1):
  - dir=1: if pos+`STEP` ≤ `LIM` then pos+=`STEP`, else dir←0 and pos held.
  - dir=0: if pos ≥ `STEP` then pos−=`STEP`, else dir←1 and pos held.
  - A flip never moves the object in the same update.
- **Reset values:**
  - Object k: x=100+300k, y=100+150k, dir_x=1, dir_y=~k[0].
  - Outputs equal the working set.
  - `busy_o`/`upd_done_o`/`overrun_o`=0, `frame_cnt_o`=0, FSM=IDLE, `vblank_q`=0.
- **Reset mid-operation:** asynchronous; returns to reset values immediately. A partially computed working set is discarded.

## Timing
- Trigger on `cen_i` cycle N → CALC at N+1.
- Object i is written at enabled cycle N+1+i; COMMIT is at N+1+`NUM_OBJ`.
- Outputs change and `upd_done_o` is high in that clk cycle.
- Latency is `NUM_OBJ`+1 enabled cycles, well inside one blanking interval.
- `cen_i` low stalls the FSM with no state loss.
- `upd_done_o` asserts only on a cycle with `cen_i`=1 and deasserts on the next clk edge.
- `busy_o` rises at N+1 and falls after COMMIT.

## Configuration
- `VIDEO_MOTION_DIV_EN` defined:
  - A divider counter of `$clog2(FRAME_DIV)` bits advances on each trigger.
  - CALC starts only when the counter is 0 before advancing; it wraps at `FRAME_DIV`-1 and resets to 0.
- Undefined: every qualifying trigger starts CALC, and `FRAME_DIV` is unused.

## Structure
- Package `video_motion_pkg`:
  - `COORD_W`=11.
  - `state_t` enum {IDLE, CALC, COMMIT}.
  - `obj_state_t` struct {x, y, dir_x, dir_y}.
  - Reset-position functions.
- Sub-module `video_motion_axis_step`: combinational single-axis step with parameters `LIM`, `STEP`, and ports pos/dir in, pos/dir out. Instantiated twice (X, Y) and muxed by `idx`.

## Test plan
- Reset with `NUM_OBJ`=2 → obj0 (100,100), obj1 (400,250); all flags 0; `frame_cnt_o`=0.
- One Vblank rise with `run_i`=1 → after 3 enabled cycles: obj0 (110,110), obj1 (410,240), one `upd_done_o` pulse, `frame_cnt_o`=1.
- Force obj0 x=1710, dir 1, over successive frames → 1720, then 1720 held with dir 0, then 1710.
- obj0 y=5, dir 0 → y held at 5 with dir 1; next frame y=15.
- Second Vblank rise during CALC → `overrun_o`=1 and stays; `frame_cnt_o`=2; only one commit.
- Assert `rst_i` mid-CALC with `cen_i` toggling 1-of-3 → outputs return to reset values immediately; no pulse. With `VIDEO_MOTION_DIV_EN` and `FRAME_DIV`=4: only triggers 1, 5, 9 commit.

Source files
------------

// File: rtl/video_motion_pkg.sv
// Shared types and reset geometry for the per-frame motion controller.
package video_motion_pkg;

    localparam int COORD_W = 11;
    localparam int AXIS_W  = 12;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        COMMIT
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               dir_x;
        logic               dir_y;
    } obj_state_t;

    function automatic logic [COORD_W-1:0] rst_x(input int k);
        return COORD_W'(100 + 300 * k);
    endfunction

    function automatic logic [COORD_W-1:0] rst_y(input int k);
        return COORD_W'(100 + 150 * k);
    endfunction

    // Objects start staggered; odd objects start moving up, even ones down.
    function automatic obj_state_t obj_rst(input int k);
        obj_state_t o;
        o.x     = rst_x(k);
        o.y     = rst_y(k);
        o.dir_x = 1'b1;
        o.dir_y = ~k[0];
        return o;
    endfunction

endpackage

// File: rtl/video_motion_axis_step.sv
// Single-axis bounce step: move by STEP toward the current direction, or
// flip direction without moving when the move would leave [0, LIM].
module video_motion_axis_step
    import video_motion_pkg::*;
#(
    parameter int LIM  = 1720,
    parameter int STEP = 10
) (
    input  logic [COORD_W-1:0] pos_i,
    input  logic               dir_i,
    output logic [COORD_W-1:0] pos_o,
    output logic               dir_o
);

    logic [AXIS_W-1:0] pos_ext;
    logic [AXIS_W-1:0] pos_up;

    assign pos_ext = {1'b0, pos_i};
    assign pos_up  = pos_ext + AXIS_W'(STEP);

    // A direction flip holds the position for this update.
    always_comb begin
        pos_o = pos_i;
        dir_o = dir_i;
        if (dir_i) begin
            if (pos_up <= AXIS_W'(LIM)) pos_o = pos_up[COORD_W-1:0];
            else                        dir_o = 1'b0;
        end else begin
            if (pos_ext >= AXIS_W'(STEP)) pos_o = COORD_W'(pos_ext - AXIS_W'(STEP));
            else                          dir_o = 1'b1;
        end
    end

endmodule

// File: rtl/video_motion_ctrl.sv
// Per-frame motion controller: on each Vblank rise, steps every object once
// (one per enabled cycle) into a working set, then commits the whole set to
// the output registers in a single cycle.
// Optional build macro: VIDEO_MOTION_DIV_EN (update only every FRAME_DIV frames).
module video_motion_ctrl
    import video_motion_pkg::*;
#(
    parameter int NUM_OBJ   = 4,
    parameter int X_MAX     = 1919,
    parameter int Y_MAX     = 1079,
    parameter int OBJ_W     = 200,
    parameter int OBJ_H     = 200,
    parameter int STEP      = 10,
    parameter int FRAME_DIV = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cen_i,
    input  logic [1:0]                 vh_blank_i,
    input  logic                       run_i,
    output logic [NUM_OBJ*COORD_W-1:0] obj_x_o,
    output logic [NUM_OBJ*COORD_W-1:0] obj_y_o,
    output logic                       busy_o,
    output logic                       upd_done_o,
    output logic                       overrun_o,
    output logic [15:0]                frame_cnt_o
);

    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OBJ - 1);

    if (NUM_OBJ < 1 || NUM_OBJ > 8 || FRAME_DIV < 1) begin : g_bad_param
        $error("video_motion_ctrl: NUM_OBJ must be 1..8 and FRAME_DIV >= 1");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vblank_q, vblank_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               overrun_q, overrun_d;
    logic               upd_done_q, upd_done_d;
    obj_state_t         work_q  [NUM_OBJ];
    obj_state_t         work_d  [NUM_OBJ];
    logic [COORD_W-1:0] out_x_q [NUM_OBJ];
    logic [COORD_W-1:0] out_x_d [NUM_OBJ];
    logic [COORD_W-1:0] out_y_q [NUM_OBJ];
    logic [COORD_W-1:0] out_y_d [NUM_OBJ];

    logic               trig, start_ok, calc_en, commit_en;
    logic               hblank_unused;
    obj_state_t         cur_obj;
    logic [COORD_W-1:0] x_next, y_next;
    logic               dx_next, dy_next;

    // Only the Vblank edge matters; Hblank is carried in the bus but unused.
    assign hblank_unused = vh_blank_i[0];
    assign trig          = cen_i & vh_blank_i[1] & ~vblank_q;

`ifdef VIDEO_MOTION_DIV_EN
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    logic [DIV_W-1:0] div_q, div_d;

    assign start_ok = (div_q == '0);

    // Frame divider: counts every trigger, motion only runs on the zero phase.
    always_comb begin
        div_d = div_q;
        if (trig) div_d = (div_q == DIV_W'(FRAME_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    end

    // Divider register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) div_q <= '0;
        else       div_q <= div_d;
    end
`else
    assign start_ok = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state: walk idx over every object, then one commit cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (trig && run_i && start_ok) begin
                    state_d = CALC;
                    idx_d   = '0;
                end
            end
            CALC: begin
                if (cen_i) begin
                    if (idx_q == IDX_LAST) state_d = COMMIT;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            COMMIT: begin
                if (cen_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: per-state enables, all qualified by the video clock enable.
    always_comb begin
        busy_o     = (state_q != IDLE);
        calc_en    = cen_i && (state_q == CALC);
        commit_en  = cen_i && (state_q == COMMIT);
        upd_done_d = commit_en;
    end

    // Frame bookkeeping: edge detector, frame counter, sticky overrun.
    always_comb begin
        vblank_d    = cen_i ? vh_blank_i[1] : vblank_q;
        frame_cnt_d = frame_cnt_q + {15'd0, trig};
        overrun_d   = overrun_q | (trig & (state_q != IDLE));
    end

    assign cur_obj = work_q[idx_q];

    video_motion_axis_step #(.LIM(X_MAX - OBJ_W + 1), .STEP(STEP)) u_step_x (
        .pos_i (cur_obj.x),
        .dir_i (cur_obj.dir_x),
        .pos_o (x_next),
        .dir_o (dx_next)
    );

    video_motion_axis_step #(.LIM(Y_MAX - OBJ_H + 1), .STEP(STEP)) u_step_y (
        .pos_i (cur_obj.y),
        .dir_i (cur_obj.dir_y),
        .pos_o (y_next),
        .dir_o (dy_next)
    );

    // Working set takes one stepped object per CALC cycle; outputs copy all at COMMIT.
    always_comb begin
        for (int k = 0; k < NUM_OBJ; k++) begin
            work_d[k]  = work_q[k];
            out_x_d[k] = out_x_q[k];
            out_y_d[k] = out_y_q[k];
            if (calc_en && (idx_q == IDX_W'(k))) begin
                work_d[k].x     = x_next;
                work_d[k].y     = y_next;
                work_d[k].dir_x = dx_next;
                work_d[k].dir_y = dy_next;
            end
            if (commit_en) begin
                out_x_d[k] = work_q[k].x;
                out_y_d[k] = work_q[k].y;
            end
        end
    end

    // Datapath and status registers; reset restores the start-of-day geometry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vblank_q    <= 1'b0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            upd_done_q  <= 1'b0;
            for (int k = 0; k < NUM_OBJ; k++) begin
                work_q[k]  <= obj_rst(k);
                out_x_q[k] <= rst_x(k);
                out_y_q[k] <= rst_y(k);
            end
        end else begin
            vblank_q    <= vblank_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            upd_done_q  <= upd_done_d;
            for (int k = 0; k < NUM_OBJ; k++) begin
                work_q[k]  <= work_d[k];
                out_x_q[k] <= out_x_d[k];
                out_y_q[k] <= out_y_d[k];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_pack
        assign obj_x_o[gi*COORD_W +: COORD_W] = out_x_q[gi];
        assign obj_y_o[gi*COORD_W +: COORD_W] = out_y_q[gi];
    end

    assign upd_done_o  = upd_done_q;
    assign overrun_o   = overrun_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
